// File: rtl/adc_frame_pkg.sv
// adc_frame_pkg: shared state types, default parameters and frame sizing helper for the ADC frame serializer
package adc_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_RD_LOW,
        S_RD_HIGH,
        S_WAIT_BUF,
        S_DRAIN
    } rd_state_t;

    typedef enum logic [1:0] {
        SH_IDLE,
        SH_LOW,
        SH_HIGH
    } sh_state_t;

    localparam int DEF_ADC_CHIPS   = 4;
    localparam int DEF_CH_PER_CHIP = 4;
    localparam int DEF_DATA_W      = 12;
    localparam int DEF_RD_LOW_CYC  = 2;
    localparam int DEF_RD_HIGH_CYC = 2;
    localparam int DEF_SCLK_DIV    = 1;
    localparam bit DEF_MSB_FIRST   = 1'b1;

    function automatic int FRAME_BITS(input int chips, input int channels, input int width);
        return chips * channels * width;
    endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// spi_word_shifter: CPOL=1/CPHA=1 word shifter with load/ready handshake, sclk divider and bit ordering
module spi_word_shifter
    import adc_frame_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SCLK_DIV  = DEF_SCLK_DIV,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              clkin,
    input  logic              rst_bar,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              idle,
    output logic              done,
    output logic              sclk,
    output logic              mosi
);
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);

    sh_state_t         state, state_nxt;
    logic [DW-1:0]     div;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sr;
    logic              half_end, last_bit;

    assign half_end = div == DW'(SCLK_DIV - 1);
    assign last_bit = bit_cnt == BW'(DATA_W - 1);
    assign idle     = state == SH_IDLE;
    // A new word may be taken on the edge that closes the last high half-period.
    assign ready    = idle || (state == SH_HIGH && half_end && last_bit);
    assign done     = ready && !idle && !load;

    always_comb begin
        state_nxt = state;
        if (load && ready)
            state_nxt = SH_LOW;
        else if (state == SH_LOW && half_end)
            state_nxt = SH_HIGH;
        else if (state == SH_HIGH && half_end)
            state_nxt = last_bit ? SH_IDLE : SH_LOW;
    end

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            state   <= SH_IDLE;
            div     <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            sclk    <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            state <= state_nxt;
            div   <= (state_nxt != state || idle) ? '0 : div + 1'b1;
            if (load && ready) begin
                sclk    <= 1'b0;
                bit_cnt <= '0;
                mosi    <= MSB_FIRST ? din[DATA_W-1] : din[0];
                sr      <= MSB_FIRST ? din << 1 : din >> 1;
            end else if (state == SH_LOW && half_end) begin
                sclk <= 1'b1;
            end else if (state == SH_HIGH && half_end && !last_bit) begin
                sclk    <= 1'b0;
                bit_cnt <= bit_cnt + 1'b1;
                mosi    <= MSB_FIRST ? sr[DATA_W-1] : sr[0];
                sr      <= MSB_FIRST ? sr << 1 : sr >> 1;
            end
        end
    end

endmodule

// File: rtl/adc_frame_serializer.sv
// adc_frame_serializer: reads every ADC chip/channel over the parallel bus and streams the words in one spi_cs frame
module adc_frame_serializer
    import adc_frame_pkg::*;
#(
    parameter int ADC_CHIPS   = DEF_ADC_CHIPS,
    parameter int CH_PER_CHIP = DEF_CH_PER_CHIP,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RD_LOW_CYC  = DEF_RD_LOW_CYC,
    parameter int RD_HIGH_CYC = DEF_RD_HIGH_CYC,
    parameter int SCLK_DIV    = DEF_SCLK_DIV,
    parameter bit MSB_FIRST   = DEF_MSB_FIRST
) (
    input  logic                 clkin,
    input  logic                 rst_bar,
    input  logic                 enable,
    input  logic [DATA_W-1:0]    db,
    output logic [ADC_CHIPS-1:0] cs_bar,
    output logic                 rd_bar,
    output logic                 sclk,
    output logic                 spi_cs,
    output logic                 mosi,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);
    localparam int CHW = $clog2(ADC_CHIPS + 1);
    localparam int CNW = $clog2(CH_PER_CHIP + 1);
    localparam int CYW = $clog2((RD_LOW_CYC > RD_HIGH_CYC ? RD_LOW_CYC : RD_HIGH_CYC) + 1);

    rd_state_t         state, state_nxt;
    logic [CHW-1:0]    chip;
    logic [CNW-1:0]    ch;
    logic [CYW-1:0]    cyc;
    logic [DATA_W-1:0] hold;
    logic              hold_valid;
    logic              sh_ready, sh_idle, sh_done, sh_load;
    logic              capture, low_end, high_end, last_ch, last_chip;

    assign low_end    = cyc == CYW'(RD_LOW_CYC - 1);
    assign high_end   = cyc == CYW'(RD_HIGH_CYC - 1);
    assign last_ch    = ch == CNW'(CH_PER_CHIP - 1);
    assign last_chip  = chip == CHW'(ADC_CHIPS - 1);
    assign capture    = state == S_RD_LOW && low_end;
    assign sh_load    = hold_valid && sh_ready;
    assign busy       = state != S_IDLE;
    assign frame_done = state == S_DRAIN && !hold_valid && sh_idle;
    assign rd_bar     = state != S_RD_LOW;
    assign cs_bar     = (busy && state != S_DRAIN) ? ~(ADC_CHIPS'(1) << chip) : '1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     state_nxt = enable ? S_CS_SETUP : S_IDLE;
            S_CS_SETUP: state_nxt = hold_valid ? S_WAIT_BUF : S_RD_LOW;
            S_WAIT_BUF: state_nxt = hold_valid ? S_WAIT_BUF : S_RD_LOW;
            S_RD_LOW:   state_nxt = low_end ? S_RD_HIGH : S_RD_LOW;
            S_RD_HIGH:
                if (high_end)
                    state_nxt = !last_ch ? (hold_valid ? S_WAIT_BUF : S_RD_LOW)
                              : last_chip ? S_DRAIN : S_CS_SETUP;
            S_DRAIN:    state_nxt = frame_done ? S_IDLE : S_DRAIN;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            state      <= S_IDLE;
            chip       <= '0;
            ch         <= '0;
            cyc        <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            spi_cs     <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            cyc   <= (state_nxt != state) ? '0 : cyc + 1'b1;
            if (state == S_IDLE && enable) begin
                chip <= '0;
                ch   <= '0;
            end else if (state == S_RD_HIGH && high_end) begin
                ch   <= last_ch ? '0 : ch + 1'b1;
                chip <= last_ch ? chip + 1'b1 : chip;
            end
            if (capture)
                hold <= db;
            // A capture on the same edge as a shifter load keeps the register full.
            hold_valid <= capture || (hold_valid && !sh_load);
            if (sh_load)
                spi_cs <= 1'b0;
            else if (state == S_DRAIN && !hold_valid && (sh_done || sh_idle))
                spi_cs <= 1'b1;
            overrun <= enable && busy;
        end
    end

    spi_word_shifter #(
        .DATA_W   (DATA_W),
        .SCLK_DIV (SCLK_DIV),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clkin  (clkin),
        .rst_bar(rst_bar),
        .load   (sh_load),
        .din    (hold),
        .ready  (sh_ready),
        .idle   (sh_idle),
        .done   (sh_done),
        .sclk   (sclk),
        .mosi   (mosi)
    );

endmodule

// File: tb/tb_adc_frame_serializer.sv
// tb_adc_frame_serializer: scoreboard bench driving four parameter sets of adc_frame_serializer in parallel
module tb_adc_frame_serializer;
    localparam int NCFG = 4;
    localparam int CFG_CHIPS [NCFG] = '{4, 4, 4, 1};
    localparam int CFG_CH    [NCFG] = '{4, 4, 4, 8};
    localparam int CFG_W     [NCFG] = '{12, 12, 12, 16};
    localparam int CFG_DIV   [NCFG] = '{1, 1, 8, 1};
    localparam int CFG_MSB   [NCFG] = '{1, 0, 1, 1};
    localparam int CFG_BASE  [NCFG] = '{0, 'h801, 0, 0};

    logic clkin = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #21 clkin = ~clkin;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int C        = CFG_CHIPS[g];
        localparam int CH       = CFG_CH[g];
        localparam int W        = CFG_W[g];
        localparam int DIV      = CFG_DIV[g];
        localparam int MSB      = CFG_MSB[g];
        localparam int BASE     = CFG_BASE[g];
        localparam int N        = C * CH;
        localparam int WORD_CYC = 2 * DIV * W;

        logic         rst_bar = 1'b1;
        logic         enable = 1'b0;
        logic         fin = 1'b0;
        logic [W-1:0] db;
        logic [C-1:0] cs_bar;
        logic         rd_bar, sclk, spi_cs, mosi, busy, frame_done, overrun;
        logic [W-1:0] q[$];
        logic [W-1:0] sh = '0;
        logic [W-1:0] exp_w;
        logic [C-1:0] exp_cs;
        logic [C-1:0] cs_q = '1;
        logic         rd_q = 1'b1, sclk_q = 1'b1, spi_q = 1'b1, cs_bad = 1'b0;
        int           chip_idx;
        int           ch_cnt = 0, nbits = 0, rises = 0, rds = 0, cs_falls = 0;
        int           frames = 0, ovs = 0, cyc = 0, last_rd = 0;

        adc_frame_serializer #(
            .ADC_CHIPS  (C),
            .CH_PER_CHIP(CH),
            .DATA_W     (W),
            .RD_LOW_CYC (2),
            .RD_HIGH_CYC(2),
            .SCLK_DIV   (DIV),
            .MSB_FIRST  (MSB != 0)
        ) dut (
            .clkin     (clkin),
            .rst_bar   (rst_bar),
            .enable    (enable),
            .db        (db),
            .cs_bar    (cs_bar),
            .rd_bar    (rd_bar),
            .sclk      (sclk),
            .spi_cs    (spi_cs),
            .mosi      (mosi),
            .busy      (busy),
            .frame_done(frame_done),
            .overrun   (overrun)
        );

        function automatic logic [W-1:0] exp_word(input int n);
            return W'(BASE + 256 * (n / CH) + n % CH);
        endfunction

        // ADC bank model: the selected chip drives its channel number for the current read
        always_comb begin
            chip_idx = 0;
            for (int i = 0; i < C; i++)
                if (!cs_bar[i]) chip_idx = i;
            db = W'(BASE + 256 * chip_idx + ch_cnt);
        end

        always @(negedge clkin) begin
            cyc++;
            if (!rst_bar) begin
                ch_cnt = 0; nbits = 0; rises = 0; rds = 0; cs_falls = 0;
                cs_q = '1; rd_q = 1'b1; sclk_q = 1'b1; spi_q = 1'b1; cs_bad = 1'b0;
                q.delete();
            end else begin
                if (cs_bar != cs_q) ch_cnt = 0;
                if (rd_q && !rd_bar) begin
                    exp_cs = '1;
                    if (rds < N) exp_cs[rds / CH] = 1'b0;
                    checks++;
                    if (rds >= N || cs_bar != exp_cs) begin
                        failures++;
                        $display("FAIL cfg%0d cs_bar at read %0d: got %b expected %b", g, rds, cs_bar, exp_cs);
                    end
                    if (rds >= 2) begin
                        checks++;
                        if (cyc - last_rd != WORD_CYC) begin
                            failures++;
                            $display("FAIL cfg%0d read spacing at read %0d: got %0d expected %0d", g, rds, cyc - last_rd, WORD_CYC);
                        end
                    end
                    last_rd = cyc;
                    rds++;
                end
                if (!rd_q && rd_bar) ch_cnt++;
                if (!spi_cs && spi_q) cs_falls++;
                if (!sclk_q && sclk) begin
                    rises++;
                    if (spi_cs) cs_bad = 1'b1;
                    sh = (MSB != 0) ? {sh[W-2:0], mosi} : {mosi, sh[W-1:1]};
                    nbits++;
                    if (nbits == W) begin
                        nbits = 0;
                        checks++;
                        if (q.size() == 0) begin
                            failures++;
                            $display("FAIL cfg%0d word: got %h with no word expected", g, sh);
                        end else begin
                            exp_w = q.pop_front();
                            if (sh !== exp_w || cs_bad) begin
                                failures++;
                                $display("FAIL cfg%0d word: got %h expected %h (spi_cs high during word=%b)", g, sh, exp_w, cs_bad);
                            end
                        end
                        cs_bad = 1'b0;
                    end
                end
                if (frame_done) begin
                    frames++;
                    checks++;
                    if (rises != N * W || rds != N || q.size() != 0 || cs_falls != 1 || !spi_cs || nbits != 0) begin
                        failures++;
                        $display("FAIL cfg%0d frame_end: rises=%0d/%0d reads=%0d/%0d words_left=%0d spi_cs_falls=%0d/1 spi_cs=%b/1 partial_bits=%0d",
                                 g, rises, N * W, rds, N, q.size(), cs_falls, spi_cs, nbits);
                    end
                    rises = 0; rds = 0; cs_falls = 0;
                end
                if (overrun) ovs++;
                cs_q = cs_bar; rd_q = rd_bar; sclk_q = sclk; spi_q = spi_cs;
            end
        end

        task automatic start_frame();
            @(negedge clkin);
            enable = 1'b1;
            for (int n = 0; n < N; n++) q.push_back(exp_word(n));
            @(negedge clkin);
            enable = 1'b0;
        endtask

        task automatic wait_frame(input int seen);
            int t = 0;
            while (frames <= seen && t < N * WORD_CYC + 500) begin
                @(negedge clkin);
                t++;
            end
            checks++;
            if (frames <= seen) begin
                failures++;
                $display("FAIL cfg%0d frame_done timeout: frames=%0d required>%0d after %0d cycles", g, frames, seen, t);
            end
        endtask

        task automatic check_reset(input string tag);
            checks++;
            if ({cs_bar, rd_bar, sclk, spi_cs, mosi, busy, frame_done, overrun} !== {{C{1'b1}}, 7'b1110000}) begin
                failures++;
                $display("FAIL cfg%0d reset_%s: got cs_bar=%b rd_bar=%b sclk=%b spi_cs=%b mosi=%b busy=%b frame_done=%b overrun=%b, expected idle values",
                         g, tag, cs_bar, rd_bar, sclk, spi_cs, mosi, busy, frame_done, overrun);
            end
        endtask

        initial begin
            #2 rst_bar = 1'b0;
            #3 check_reset("power_on");
            repeat (3) @(negedge clkin);
            rst_bar = 1'b1;
            repeat (2) @(negedge clkin);
            start_frame();
            wait_frame(0);
            start_frame();
            repeat (49) @(negedge clkin);
            enable = 1'b1;
            @(negedge clkin);
            enable = 1'b0;
            wait_frame(1);
            checks++;
            if (ovs != 1) begin
                failures++;
                $display("FAIL cfg%0d overrun pulses: got %0d expected 1", g, ovs);
            end
            start_frame();
            repeat (40 + WORD_CYC / 2) @(negedge clkin);
            #7 rst_bar = 1'b0;
            #1 check_reset("mid_frame");
            repeat (3) @(negedge clkin);
            rst_bar = 1'b1;
            repeat (2) @(negedge clkin);
            start_frame();
            wait_frame(2);
            checks++;
            if (frames != 3 || ovs != 1) begin
                failures++;
                $display("FAIL cfg%0d totals: frames=%0d expected 3, overruns=%0d expected 1", g, frames, ovs);
            end
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 60000) begin
            @(negedge clkin);
            t++;
        end
        if (t >= 60000) begin
            failures++;
            $display("FAIL all_configs_done: timeout after %0d cycles", t);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
